// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one spi_master between requesters A and B,
// with a CS-idle gap between transfers and a watchdog on stuck transfers.
module spi_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic [DATA_WIDTH-1:0] tx_data_a,
  output logic                  ack_a,
  output logic                  done_a,
  output logic                  err_a,
  output logic [DATA_WIDTH-1:0] rx_data_a,
  input  logic                  req_b,
  input  logic [DATA_WIDTH-1:0] tx_data_b,
  output logic                  ack_b,
  output logic                  done_b,
  output logic                  err_b,
  output logic [DATA_WIDTH-1:0] rx_data_b,
  output logic                  spi_run,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  input  logic                  spi_tx_done,
  input  logic                  spi_rx_done,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  output logic                  busy,
  output logic                  grant_b
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t                state, state_n;
  logic                  last_owner, last_owner_n;
  logic                  tx_seen, tx_seen_n;
  logic                  rx_seen, rx_seen_n;
  logic [DATA_WIDTH-1:0] rx_cap, rx_cap_n;
  logic [TW-1:0]         tmo_cnt, tmo_cnt_n;
  logic [GW-1:0]         gap_cnt, gap_cnt_n;

  logic                  spi_run_n, grant_b_n, busy_n;
  logic [DATA_WIDTH-1:0] spi_tx_data_n, rx_data_a_n, rx_data_b_n;
  logic                  ack_a_n, ack_b_n, done_a_n, done_b_n, err_a_n, err_b_n;

  logic                  winner, tx_hit, rx_hit, rx_first;
  logic [DATA_WIDTH-1:0] rx_byte;

  always_comb begin
    state_n       = state;
    last_owner_n  = last_owner;
    tx_seen_n     = tx_seen;
    rx_seen_n     = rx_seen;
    rx_cap_n      = rx_cap;
    tmo_cnt_n     = tmo_cnt;
    gap_cnt_n     = gap_cnt;
    spi_run_n     = spi_run;
    grant_b_n     = grant_b;
    spi_tx_data_n = spi_tx_data;
    rx_data_a_n   = rx_data_a;
    rx_data_b_n   = rx_data_b;
    ack_a_n       = 1'b0;
    ack_b_n       = 1'b0;
    done_a_n      = 1'b0;
    done_b_n      = 1'b0;
    err_a_n       = 1'b0;
    err_b_n       = 1'b0;
    winner        = 1'b0;
    tx_hit        = 1'b0;
    rx_hit        = 1'b0;
    rx_first      = 1'b0;
    rx_byte       = rx_cap;

    unique case (state)
      IDLE: begin
        if (req_a || req_b) begin
          // On a tie the requester that did not own the last transfer wins.
          winner        = (req_a && req_b) ? ~last_owner : req_b;
          state_n       = RUN;
          spi_tx_data_n = winner ? tx_data_b : tx_data_a;
          grant_b_n     = winner;
          last_owner_n  = winner;
          ack_a_n       = ~winner;
          ack_b_n       = winner;
          spi_run_n     = 1'b1;
          tmo_cnt_n     = '0;
          tx_seen_n     = 1'b0;
          rx_seen_n     = 1'b0;
        end
      end

      RUN: begin
        tx_hit    = tx_seen | spi_tx_done;
        rx_hit    = rx_seen | spi_rx_done;
        rx_first  = spi_rx_done & ~rx_seen;
        rx_byte   = rx_first ? spi_rx_data : rx_cap;
        tx_seen_n = tx_hit;
        rx_seen_n = rx_hit;
        if (rx_first) rx_cap_n = spi_rx_data;

        // Completion is checked before the watchdog so it wins a same-edge tie.
        if (tx_hit && rx_hit) begin
          state_n   = GAP;
          gap_cnt_n = '0;
          spi_run_n = 1'b0;
          if (grant_b) begin
            done_b_n    = 1'b1;
            rx_data_b_n = rx_byte;
          end else begin
            done_a_n    = 1'b1;
            rx_data_a_n = rx_byte;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_n   = GAP;
          gap_cnt_n = '0;
          spi_run_n = 1'b0;
          done_a_n  = ~grant_b;
          err_a_n   = ~grant_b;
          done_b_n  = grant_b;
          err_b_n   = grant_b;
        end else begin
          tmo_cnt_n = tmo_cnt + TW'(1);
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
        else gap_cnt_n = gap_cnt + GW'(1);
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      tx_seen     <= 1'b0;
      rx_seen     <= 1'b0;
      rx_cap      <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      spi_run     <= 1'b0;
      grant_b     <= 1'b0;
      busy        <= 1'b0;
      spi_tx_data <= '0;
      rx_data_a   <= '0;
      rx_data_b   <= '0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      done_a      <= 1'b0;
      done_b      <= 1'b0;
      err_a       <= 1'b0;
      err_b       <= 1'b0;
    end else begin
      state       <= state_n;
      last_owner  <= last_owner_n;
      tx_seen     <= tx_seen_n;
      rx_seen     <= rx_seen_n;
      rx_cap      <= rx_cap_n;
      tmo_cnt     <= tmo_cnt_n;
      gap_cnt     <= gap_cnt_n;
      spi_run     <= spi_run_n;
      grant_b     <= grant_b_n;
      busy        <= busy_n;
      spi_tx_data <= spi_tx_data_n;
      rx_data_a   <= rx_data_a_n;
      rx_data_b   <= rx_data_b_n;
      ack_a       <= ack_a_n;
      ack_b       <= ack_b_n;
      done_a      <= done_a_n;
      done_b      <= done_b_n;
      err_a       <= err_a_n;
      err_b       <= err_b_n;
    end
  end

endmodule
